// File: rtl/control_multi.sv
// control_multi: multi-cycle MIPS control FSM.
//
// Sequences a shared-memory multi-cycle datapath (IR/PC/A/B/ALUOut) through
// fetch, decode, execute, memory and writeback steps for R-format, LW, SW,
// BEQ, BNE, J and ADDIU. Every memory access waits on mem_ready, so a slow
// memory stalls the FSM with all strobes held stable.
//
// Parameters:
//   ILLEGAL_HALT - 1: illegal opcode parks the FSM in HALT until reset.
//                  0: illegal opcode is a NOP, FSM returns to FETCH.
//   CNT_W        - performance counter width (CONTROL_MULTI_PERF_EN only).
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   instr           - current IR contents, sampled only in DECODE
//   mem_ready       - memory completes the current access this cycle
//   PCWrite, PCWriteCond, Bne, PCSource        - PC update control
//   IorD, MemRead, MemWrite, IRWrite           - memory / IR control
//   MemtoReg, RegDst, RegWrite                 - register file control
//   ALUSrcA, ALUSrcB, ALUOp                    - ALU operand/op select
//   state           - current state code (debug)
//   halted          - high while in HALT
//   cyc_cnt, instr_cnt - performance counters (CONTROL_MULTI_PERF_EN only)
//
// Optional feature macro: CONTROL_MULTI_PERF_EN. When undefined the counter
// ports and logic are absent and behaviour is otherwise identical.

module control_multi #(
  parameter bit ILLEGAL_HALT = 1'b1
`ifdef CONTROL_MULTI_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Bne,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        halted
`ifdef CONTROL_MULTI_PERF_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    StRst     = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StRwb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StAddiEx  = 4'd11,
    StAddiWb  = 4'd12,
    StHalt    = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpAddiu = 6'd9;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] opcode;

  assign opcode = instr[31:26];

  // ---------------------------------------------------------------------------
  // State and opcode registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRst;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode is captured in DECODE so later states do not depend on instr.
  always_comb begin
    op_d = op_q;
    if (state_q == StDecode) begin
      op_d = opcode;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (instr == 32'd0) begin
          state_d = StFetch;
        end else begin
          case (opcode)
            OpRtype:      state_d = StExec;
            OpLw, OpSw:   state_d = StMemAdr;
            OpBeq, OpBne: state_d = StBranch;
            OpJ:          state_d = StJump;
            OpAddiu:      state_d = StAddiEx;
            default:      state_d = ILLEGAL_HALT ? StHalt : StFetch;
          endcase
        end
      end
      StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StHalt:   state_d = StHalt;
      // Codes 14/15 are unreachable; recover through RST.
      default:  state_d = StRst;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore, except IRWrite/PCWrite in FETCH follow mem_ready)
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Bne         = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    halted      = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and IR load only on the cycle the read completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
      end
      StMemAdr, StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StRwb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        Bne         = (op_q == OpBne);
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef CONTROL_MULTI_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != StRst && state_q != StHalt) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end
    // A FETCH hold is not a new instruction; only entries into FETCH count.
    if (state_d == StFetch && state_q != StFetch && state_q != StRst) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
